// File: rtl/rsc_encoder_param_if.sv
// Control and stream bundle for rsc_encoder_param.
// With RSC_PARITY_COUNT_EN defined the bundle also carries parity_ones.
interface rsc_encoder_param_if #(
  parameter int KW = 13
);
  logic          start;
  logic [KW-1:0] k_len;
  logic          ck;
  logic          in_valid;
  logic          xk;
  logic          zk;
  logic          out_valid;
  logic          tail;
  logic          busy;
  logic          done;
  logic          err;
  logic [2:0]    dd;
`ifdef RSC_PARITY_COUNT_EN
  logic [KW-1:0] parity_ones;

  modport master (
    output start, k_len, ck, in_valid,
    input  xk, zk, out_valid, tail, busy, done, err, dd, parity_ones
  );

  modport slave (
    input  start, k_len, ck, in_valid,
    output xk, zk, out_valid, tail, busy, done, err, dd, parity_ones
  );
`else
  modport master (
    output start, k_len, ck, in_valid,
    input  xk, zk, out_valid, tail, busy, done, err, dd
  );

  modport slave (
    input  start, k_len, ck, in_valid,
    output xk, zk, out_valid, tail, busy, done, err, dd
  );
`endif
endinterface

// File: rtl/rsc_encoder_param.sv
// 8-state LTE constituent RSC encoder (g0=1+D^2+D^3, g1=1+D+D^3) with run-time K and auto termination.
// Optional RSC_PARITY_COUNT_EN: counts zk=1 outputs of the current block on parity_ones.
//
// state | meaning
// IDLE  | waiting for start; err pulses on an illegal k_len
// DATA  | accepting K qualified input bits
// TAIL  | emitting the 3 trellis termination bits
module rsc_encoder_param #(
  parameter int KW   = 13,
  parameter int KMIN = 40,
  parameter int KMAX = 6144
) (
  input logic               clk,
  input logic               aclr,
  rsc_encoder_param_if.slave bus
);

  typedef enum logic [1:0] {IDLE, DATA, TAIL} state_t;

  state_t        state;
  logic [KW-1:0] k_reg;
  logic [KW-1:0] bit_cnt;
  logic [KW-1:0] bit_cnt_nxt;
  logic [1:0]    tail_cnt;
  logic [2:0]    q;
  logic          xk_r, zk_r, out_valid_r, tail_r, done_r, err_r;
  logic          k_legal;
  logic          s_data, z_data, x_tail, z_tail;

  assign k_legal     = (bus.k_len >= KW'(KMIN)) && (bus.k_len <= KW'(KMAX));
  assign s_data      = bus.ck ^ q[1] ^ q[2];
  assign z_data      = s_data ^ q[0] ^ q[2];
  // Tail input is chosen so feedback is zero; the register drains to 000 in 3 shifts.
  assign x_tail      = q[1] ^ q[2];
  assign z_tail      = q[0] ^ q[2];
  assign bit_cnt_nxt = bit_cnt + 1'b1;

  always_ff @(posedge clk) begin
    if (aclr) begin
      state       <= IDLE;
      k_reg       <= '0;
      bit_cnt     <= '0;
      tail_cnt    <= '0;
      q           <= '0;
      xk_r        <= 1'b0;
      zk_r        <= 1'b0;
      out_valid_r <= 1'b0;
      tail_r      <= 1'b0;
      done_r      <= 1'b0;
      err_r       <= 1'b0;
    end else begin
      done_r <= 1'b0;
      err_r  <= 1'b0;
      case (state)
        IDLE: begin
          out_valid_r <= 1'b0;
          tail_r      <= 1'b0;
          if (bus.start) begin
            if (k_legal) begin
              state    <= DATA;
              k_reg    <= bus.k_len;
              bit_cnt  <= '0;
              tail_cnt <= '0;
              q        <= '0;
            end else begin
              err_r <= 1'b1;
            end
          end
        end
        DATA: begin
          tail_r <= 1'b0;
          if (bus.in_valid) begin
            xk_r        <= bus.ck;
            zk_r        <= z_data;
            out_valid_r <= 1'b1;
            q           <= {q[1], q[0], s_data};
            bit_cnt     <= bit_cnt_nxt;
            if (bit_cnt_nxt == k_reg) begin
              state    <= TAIL;
              tail_cnt <= '0;
            end
          end else begin
            out_valid_r <= 1'b0;
          end
        end
        TAIL: begin
          xk_r        <= x_tail;
          zk_r        <= z_tail;
          out_valid_r <= 1'b1;
          tail_r      <= 1'b1;
          q           <= {q[1], q[0], 1'b0};
          tail_cnt    <= tail_cnt + 1'b1;
          if (tail_cnt == 2'd2) begin
            done_r   <= 1'b1;
            state    <= IDLE;
            tail_cnt <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.xk        = xk_r;
  assign bus.zk        = zk_r;
  assign bus.out_valid = out_valid_r;
  assign bus.tail      = tail_r;
  assign bus.busy      = (state != IDLE);
  assign bus.done      = done_r;
  assign bus.err       = err_r;
  assign bus.dd        = q;

`ifdef RSC_PARITY_COUNT_EN
  logic [KW-1:0] par_cnt;

  always_ff @(posedge clk) begin
    if (aclr) begin
      par_cnt <= '0;
    end else if (state == IDLE && bus.start && k_legal) begin
      par_cnt <= '0;
    end else if ((state == DATA && bus.in_valid && z_data) || (state == TAIL && z_tail)) begin
      par_cnt <= par_cnt + 1'b1;
    end
  end

  assign bus.parity_ones = par_cnt;
`endif

endmodule

// File: tb/tb_rsc_encoder_param.sv
// Scoreboard bench for rsc_encoder_param: a reference RSC model queues expected outputs as bits are driven.
module tb_rsc_encoder_param;
  localparam int KW = 13;

  logic clk = 1'b0;
  logic aclr;
  always #5 clk = ~clk;

  rsc_encoder_param_if #(.KW(KW)) bus ();
  rsc_encoder_param #(.KW(KW), .KMIN(40), .KMAX(6144)) dut (
    .clk (clk),
    .aclr(aclr),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;

  bit         exp_x[$], exp_z[$], exp_t[$];
  bit         obs_x[$], obs_z[$], obs_t[$];
  logic [2:0] obs_dd[$];
  logic [2:0] mq;
  int         exp_ones;
  int         done_cnt, done_idx, ov_cnt, err_seen, busy_after_start, busy_at_done;
  logic [2:0] dd_at_done;
  logic [KW-1:0] par_at_done;

  function automatic void model_step(input bit c, input bit is_tail);
    bit cin, s, z;
    cin = is_tail ? (mq[1] ^ mq[2]) : c;
    s   = cin ^ mq[1] ^ mq[2];
    z   = s ^ mq[0] ^ mq[2];
    exp_x.push_back(cin);
    exp_z.push_back(z);
    exp_t.push_back(is_tail);
    if (z) exp_ones++;
    mq = {mq[1], mq[0], s};
  endfunction

  task automatic capture();
    if (bus.out_valid) begin
      ov_cnt++;
      obs_x.push_back(bus.xk);
      obs_z.push_back(bus.zk);
      obs_t.push_back(bus.tail);
      obs_dd.push_back(bus.dd);
    end
    if (bus.err) err_seen++;
    if (bus.done) begin
      done_cnt++;
      done_idx     = ov_cnt;
      dd_at_done   = bus.dd;
      busy_at_done = int'(bus.busy);
`ifdef RSC_PARITY_COUNT_EN
      par_at_done  = bus.parity_ones;
`else
      par_at_done  = '0;
`endif
    end
  endtask

  // mode 0: 1,0,1,1 then zeros; mode 1: zeros with last bit 1; mode 2: random bits
  task automatic drive_block(input int k, input int mode, input int gap_pct, input int mid_start_at);
    int acc, cyc;
    bit v, b;
    exp_x.delete(); exp_z.delete(); exp_t.delete();
    obs_x.delete(); obs_z.delete(); obs_t.delete(); obs_dd.delete();
    mq = 3'b000; exp_ones = 0;
    done_cnt = 0; done_idx = -1; ov_cnt = 0; err_seen = 0; busy_at_done = -1;
    dd_at_done = 3'bxxx; par_at_done = '0;
    bus.start = 1'b1; bus.k_len = KW'(k); bus.in_valid = 1'b0; bus.ck = 1'b0;
    @(posedge clk); #1;
    capture();
    busy_after_start = int'(bus.busy);
    bus.start = 1'b0;
    acc = 0; cyc = 0;
    while (acc < k && cyc < 20 * k) begin
      v = ($urandom_range(99) >= gap_pct);
      case (mode)
        0:       b = (acc == 0 || acc == 2 || acc == 3);
        1:       b = (acc == k - 1);
        default: b = 1'($urandom_range(1));
      endcase
      bus.in_valid = v;
      bus.ck       = b;
      bus.start    = (cyc == mid_start_at);
      bus.k_len    = (cyc == mid_start_at) ? KW'(100) : KW'(k);
      if (v) begin
        model_step(b, 1'b0);
        acc++;
      end
      @(posedge clk); #1;
      capture();
      cyc++;
    end
    bus.start = 1'b0;
    bus.k_len = KW'(k);
    for (int t = 0; t < 3; t++) model_step(1'b0, 1'b1);
    for (int t = 0; t < 8 && done_cnt == 0; t++) begin
      bus.in_valid = 1'($urandom_range(1));
      bus.ck       = 1'($urandom_range(1));
      @(posedge clk); #1;
      capture();
    end
    bus.in_valid = 1'b0;
    bus.ck       = 1'b0;
  endtask

  task automatic test_reset();
    aclr = 1'b1;
    for (int i = 0; i < 2; i++) begin
      bus.start    = 1'($urandom_range(1));
      bus.k_len    = KW'($urandom_range(8191));
      bus.ck       = 1'($urandom_range(1));
      bus.in_valid = 1'($urandom_range(1));
      @(posedge clk); #1;
    end
    checks++;
    if ({bus.xk, bus.zk, bus.out_valid, bus.tail, bus.busy, bus.done, bus.err, bus.dd} !== 10'b0) begin
      failures++;
      $display("FAIL reset_outputs got=%b required=0000000000",
               {bus.xk, bus.zk, bus.out_valid, bus.tail, bus.busy, bus.done, bus.err, bus.dd});
    end
`ifdef RSC_PARITY_COUNT_EN
    checks++;
    if (bus.parity_ones !== '0) begin
      failures++;
      $display("FAIL reset_parity_ones got=%0d required=0", bus.parity_ones);
    end
`endif
    aclr = 1'b0; bus.start = 1'b0; bus.in_valid = 1'b1; bus.ck = 1'b1;
    ov_cnt = 0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      if (bus.out_valid || bus.busy) ov_cnt++;
    end
    bus.in_valid = 1'b0; bus.ck = 1'b0;
    checks++;
    if (ov_cnt !== 0) begin
      failures++;
      $display("FAIL idle_ignores_in_valid active_cycles=%0d required=0", ov_cnt);
    end
  endtask

  task automatic test_pattern_a();
    bit req_z[4] = '{1'b1, 1'b1, 1'b0, 1'b1};
    int mism;
    drive_block(40, 0, 0, -1);
    checks++;
    if (busy_after_start !== 1) begin
      failures++;
      $display("FAIL busy_after_start got=%0d required=1", busy_after_start);
    end
    checks++;
    if (ov_cnt !== 43) begin
      failures++;
      $display("FAIL patA_out_count got=%0d required=43", ov_cnt);
    end
    mism = 0;
    for (int i = 0; i < 4; i++) if (obs_z[i] !== req_z[i]) mism++;
    checks++;
    if (mism != 0) begin
      failures++;
      $display("FAIL patA_first4_zk got=%b%b%b%b required=1101", obs_z[0], obs_z[1], obs_z[2], obs_z[3]);
    end
    checks++;
    if (obs_dd[3] !== 3'b000) begin
      failures++;
      $display("FAIL patA_dd_after_bit4 got=%b required=000", obs_dd[3]);
    end
    checks++;
    if ({obs_x[40], obs_x[41], obs_x[42], obs_z[40], obs_z[41], obs_z[42]} !== 6'b0) begin
      failures++;
      $display("FAIL patA_tail got_x=%b%b%b got_z=%b%b%b required 000/000",
               obs_x[40], obs_x[41], obs_x[42], obs_z[40], obs_z[41], obs_z[42]);
    end
    checks++;
    if (done_cnt !== 1 || done_idx !== 43) begin
      failures++;
      $display("FAIL patA_done count=%0d at_output=%0d required 1 at 43", done_cnt, done_idx);
    end
    mism = 0;
    while (exp_x.size() > 0 && obs_x.size() > 0) begin
      if ({obs_x.pop_front(), obs_z.pop_front(), obs_t.pop_front()} !==
          {exp_x.pop_front(), exp_z.pop_front(), exp_t.pop_front()}) mism++;
    end
    checks++;
    if (mism != 0 || exp_x.size() != 0 || obs_x.size() != 0) begin
      failures++;
      $display("FAIL patA_scoreboard mismatches=%0d left_exp=%0d left_obs=%0d required 0/0/0",
               mism, exp_x.size(), obs_x.size());
    end
  endtask

  task automatic test_pattern_b();
    bit req_x[3] = '{1'b0, 1'b1, 1'b1};
    bit req_z[3] = '{1'b1, 1'b0, 1'b1};
    int mism;
    drive_block(40, 1, 0, -1);
    checks++;
    if (obs_z[39] !== 1'b1) begin
      failures++;
      $display("FAIL patB_bit40_zk got=%b required=1", obs_z[39]);
    end
    mism = 0;
    for (int i = 0; i < 3; i++) begin
      if (obs_x[40 + i] !== req_x[i] || obs_z[40 + i] !== req_z[i] || obs_t[40 + i] !== 1'b1) mism++;
    end
    checks++;
    if (mism != 0) begin
      failures++;
      $display("FAIL patB_tail got_x=%b%b%b got_z=%b%b%b required 011/101",
               obs_x[40], obs_x[41], obs_x[42], obs_z[40], obs_z[41], obs_z[42]);
    end
    checks++;
    if (dd_at_done !== 3'b000 || busy_at_done !== 0) begin
      failures++;
      $display("FAIL patB_done_state dd=%b busy=%0d required dd=000 busy=0", dd_at_done, busy_at_done);
    end
`ifdef RSC_PARITY_COUNT_EN
    checks++;
    if (par_at_done !== KW'(3)) begin
      failures++;
      $display("FAIL patB_parity_ones got=%0d required=3", par_at_done);
    end
`endif
  endtask

  task automatic test_random_kmax();
    int mism;
    drive_block(6144, 2, 30, 3000);
    checks++;
    if (ov_cnt !== 6147) begin
      failures++;
      $display("FAIL kmax_out_count got=%0d required=6147", ov_cnt);
    end
    checks++;
    if (done_cnt !== 1 || err_seen !== 0 || dd_at_done !== 3'b000) begin
      failures++;
      $display("FAIL kmax_done done=%0d err=%0d dd=%b required 1/0/000", done_cnt, err_seen, dd_at_done);
    end
    mism = 0;
    while (exp_x.size() > 0 && obs_x.size() > 0) begin
      if ({obs_x.pop_front(), obs_z.pop_front(), obs_t.pop_front()} !==
          {exp_x.pop_front(), exp_z.pop_front(), exp_t.pop_front()}) mism++;
    end
    checks++;
    if (mism != 0 || exp_x.size() != 0 || obs_x.size() != 0) begin
      failures++;
      $display("FAIL kmax_scoreboard mismatches=%0d left_exp=%0d left_obs=%0d required 0/0/0",
               mism, exp_x.size(), obs_x.size());
    end
`ifdef RSC_PARITY_COUNT_EN
    checks++;
    if (par_at_done !== KW'(exp_ones)) begin
      failures++;
      $display("FAIL kmax_parity_ones got=%0d required=%0d", par_at_done, exp_ones);
    end
`endif
  endtask

  task automatic test_illegal_len();
    int bad[2] = '{39, 6145};
    for (int i = 0; i < 2; i++) begin
      bus.start = 1'b1; bus.k_len = KW'(bad[i]);
      @(posedge clk); #1;
      bus.start = 1'b0;
      checks++;
      if (bus.err !== 1'b1 || bus.busy !== 1'b0) begin
        failures++;
        $display("FAIL illegal_k%0d err=%b busy=%b required err=1 busy=0", bad[i], bus.err, bus.busy);
      end
      @(posedge clk); #1;
      checks++;
      if (bus.err !== 1'b0 || bus.busy !== 1'b0) begin
        failures++;
        $display("FAIL illegal_k%0d_after err=%b busy=%b required 0/0", bad[i], bus.err, bus.busy);
      end
    end
  endtask

  task automatic test_abort();
    int seen;
    bus.start = 1'b1; bus.k_len = KW'(1056);
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (int i = 0; i < 99; i++) begin
      bus.in_valid = 1'b1; bus.ck = 1'($urandom_range(1));
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b1; bus.ck = 1'b1; aclr = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({bus.xk, bus.zk, bus.out_valid, bus.tail, bus.busy, bus.done, bus.err, bus.dd} !== 10'b0) begin
      failures++;
      $display("FAIL abort_outputs got=%b required=0000000000",
               {bus.xk, bus.zk, bus.out_valid, bus.tail, bus.busy, bus.done, bus.err, bus.dd});
    end
`ifdef RSC_PARITY_COUNT_EN
    checks++;
    if (bus.parity_ones !== '0) begin
      failures++;
      $display("FAIL abort_parity_ones got=%0d required=0", bus.parity_ones);
    end
`endif
    aclr = 1'b0;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (bus.done || bus.out_valid || bus.busy) seen++;
    end
    bus.in_valid = 1'b0; bus.ck = 1'b0;
    checks++;
    if (seen !== 0) begin
      failures++;
      $display("FAIL abort_no_done active_cycles=%0d required=0", seen);
    end
  endtask

  task automatic test_back_to_back();
    int mism;
    drive_block(40, 2, 20, -1);
    checks++;
    if (done_cnt !== 1 || ov_cnt !== 43) begin
      failures++;
      $display("FAIL b2b_first done=%0d outs=%0d required 1/43", done_cnt, ov_cnt);
    end
    drive_block(45, 2, 0, -1);
    checks++;
    if (busy_after_start !== 1 || done_cnt !== 1 || ov_cnt !== 48) begin
      failures++;
      $display("FAIL b2b_second busy=%0d done=%0d outs=%0d required 1/1/48", busy_after_start, done_cnt, ov_cnt);
    end
    mism = 0;
    while (exp_x.size() > 0 && obs_x.size() > 0) begin
      if ({obs_x.pop_front(), obs_z.pop_front(), obs_t.pop_front()} !==
          {exp_x.pop_front(), exp_z.pop_front(), exp_t.pop_front()}) mism++;
    end
    checks++;
    if (mism != 0 || exp_x.size() != 0 || obs_x.size() != 0) begin
      failures++;
      $display("FAIL b2b_scoreboard mismatches=%0d left_exp=%0d left_obs=%0d required 0/0/0",
               mism, exp_x.size(), obs_x.size());
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    aclr = 1'b1; bus.start = 1'b0; bus.k_len = '0; bus.ck = 1'b0; bus.in_valid = 1'b0;
    test_reset();
    test_pattern_a();
    test_pattern_b();
    test_random_kmax();
    test_illegal_len();
    test_abort();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/rsc_encoder_param.md
# rsc_encoder_param

Parametrised 8-state constituent RSC encoder for the LTE turbo encoder datapath. It uses generators g0 = 1+D²+D³ (feedback) and g1 = 1+D+D³ (parity). The block length K is set at run time per block, and input can stall on a valid qualifier. After the K-th bit it appends the 3-cycle trellis termination on its own. It sits between the interleaver/input buffer and the rate-matching stage, with one instance per constituent encoder.

## Interface
- KW, 13, width of block-length and count fields; KMAX < 2^KW required
- KMIN, 40, smallest legal block length
- KMAX, 6144, largest legal block length

- clk  in  1  clock; all logic on rising edge
- aclr  in  1  synchronous, active-high reset
- start  in  1  one-cycle block start request, sampled only in IDLE
- k_len  in  KW  block length, sampled with start
- ck  in  1  systematic input bit
- in_valid  in  1  ck qualifier, honoured only in DATA
- xk  out  1  systematic/tail output bit (registered)
- zk  out  1  parity output bit (registered)
- out_valid  out  1  xk/zk valid this cycle
- tail  out  1  current output is a termination bit
- busy  out  1  state ≠ IDLE
- done  out  1  one-cycle pulse with the third tail output
- err  out  1  one-cycle pulse: start with illegal k_len
- dd  out  3  shift register {q2,q1,q0}, for debug

## Operation
- Shift register q0,q1,q2. Feedback s = c ^ q1 ^ q2. Parity z = s ^ q0 ^ q2. Update: q0←s, q1←q0, q2←q1.
- States:
  - IDLE → DATA: on start with KMIN ≤ k_len ≤ KMAX. Latch K, clear the bit counter, clear q to 000.
  - IDLE, start with illegal k_len: err=1 next cycle, remain IDLE, q untouched.
  - DATA: each edge with in_valid=1 accepts ck. Outputs register xk←ck, zk←z, out_valid←1, tail←0. The counter increments. On the K-th acceptance the state → TAIL.
  - DATA, in_valid=0: no shift, out_valid←0, counter held. Stalls are unbounded.
  - TAIL: 3 edges, with tail counter 0..2 and in_valid ignored.
    - Input c = q1^q2, so s=0.
    - xk←q1^q2, zk←q0^q2, out_valid←1, tail←1.
    - On the third edge: done←1, state → IDLE. q must then be 000.
- start and k_len are ignored while busy. No err is raised for them and the current block is unaffected.
- in_valid is ignored in IDLE.
- Counters are KW bits wide and never wrap, because K ≤ KMAX < 2^KW.

## Timing
- Reset values: all of the following are 0, and state=IDLE.
  - xk, zk, out_valid, tail, busy, done, err, dd, counters.
- Reset has priority over every other input. Asserted mid-block, it aborts the block at that edge: no done is produced and no partial tail is emitted.
- start sampled at edge E → busy=1 from E. The first ck can be accepted at E+1.
- Latency is 1 cycle: a bit accepted at edge m appears on xk/zk/out_valid during cycle m→m+1.
- Tail timing, with the K-th bit accepted at edge m:
  - Tail outputs are registered at m+1, m+2, m+3.
  - done=1 and busy=0 from m+3.
  - A start sampled at m+4 is accepted, so there is 0 idle-cycle penalty beyond done.
- Output word count per block is exactly K+3 cycles with out_valid=1.

## Configuration
- RSC_PARITY_COUNT_EN
  - Defined: adds output parity_ones [KW-1:0], which counts zk=1 over the K data bits plus the 3 tail bits of the current block. It is cleared on an accepted start and by aclr, and held after done until the next accepted start.
  - Undefined: the port and the counter are absent, and all other behaviour is identical.

## Test plan
- Reset: hold aclr 2 cycles with random inputs → all outputs 0, busy=0.
- K=40, ck=1,0,1,1 then 36 zeros, in_valid held high:
  - zk for the first 4 bits = 1,1,0,1.
  - dd=000 after bit 4.
  - Tail xk=0,0,0, zk=0,0,0.
  - done at the 43rd output.
- K=40, ck=0 except bit 40 =1:
  - bit 40 has zk=1.
  - Tail xk=0,1,1, zk=1,0,1.
  - dd=000 after done.
  - With RSC_PARITY_COUNT_EN defined, parity_ones=3.
- K=6144 with random in_valid gaps (≈30% low), compared against a golden model:
  - exactly 6147 out_valid pulses.
  - bit-exact xk/zk.
  - start pulsed mid-block is ignored.
- Illegal length:
  - start with k_len=39 → err pulse, busy stays 0.
  - start with k_len=6145 → err pulse, busy stays 0.
- Abort and back-to-back:
  - aclr at bit 100 of K=1056 → outputs 0 next cycle, no done.
  - A new start sampled the cycle after a done → a second block runs with correct output.
